// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// One requester's request/response bundle for the data-memory arbiter.
//   valid      : request present                  (requester -> arbiter)
//   ready      : request accepted this cycle      (arbiter -> requester)
//   we         : 1 = store, 0 = load              (requester -> arbiter)
//   addr       : byte address, bits [1:0] ignored (requester -> arbiter)
//   wdata      : store data, lane i = [8i+7:8i]   (requester -> arbiter)
//   be         : store byte enables               (requester -> arbiter)
//   resp_valid : one-cycle completion pulse       (arbiter -> requester)
//   resp_rdata : load data                        (arbiter -> requester)
//   resp_err   : out-of-range access              (arbiter -> requester)
// ----------------------------------------------------------------------------
interface dmem_arbiter_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output valid, we, addr, wdata, be,
        input  ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  valid, we, addr, wdata, be,
        output ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter in front of a single-port data memory. Requests are
// accepted one at a time, round-robin when both ports are valid. Partial
// stores are done as read-modify-write.
//   clk            : single clock, rising-edge state updates
//   rst_n          : asynchronous active-low reset
//   req0, req1     : requester bundles (dmem_arbiter_if.slave)
//   mem_addr_o     : word-aligned byte address to the memory
//   mem_data_in_o  : write data to the memory
//   mem_wr_en_o    : write strobe, sampled by the memory on falling clk
//   mem_data_out_i : combinational read data from the memory
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a request; grants and latches one
// ACCESS   | address memory; load capture, full store, or RMW read
// MERGE_WR | write back the merged word of a partial store
// RESP     | one-cycle response pulse to the granted port
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MEM_BYTES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        req0,
    dmem_arbiter_if.slave        req1,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_data_in_o,
    output logic                 mem_wr_en_o,
    input  logic [31:0]          mem_data_out_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;   // reused to hold the merged word during MERGE_WR
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        grant;
    logic        rdy0, rdy1;
    logic        in_range;
    logic [31:0] merged;

    assign in_range = ({1'b0, addr_q} < MEM_LIMIT);

    // Lane-wise merge of new store data over the current memory word.
    always_comb begin
        merged = mem_data_out_i;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    // Both valid: the port that did not win last time wins now.
    assign grant = (req0.valid && req1.valid) ? ~last_grant_q : req1.valid;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        gnt_d         = gnt_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        rdy0          = 1'b0;
        rdy1          = 1'b0;
        mem_addr_o    = 32'h0;
        mem_data_in_o = 32'h0;
        mem_wr_en_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0.valid || req1.valid) begin
                    rdy0         = ~grant;
                    rdy1         = grant;
                    gnt_d        = grant;
                    last_grant_d = grant;
                    we_d         = grant ? req1.we    : req0.we;
                    addr_d       = grant ? req1.addr  : req0.addr;
                    wdata_d      = grant ? req1.wdata : req0.wdata;
                    be_d         = grant ? req1.be    : req0.be;
                    rdata_d      = 32'h0;
                    err_d        = 1'b0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_o = {addr_q[31:2], 2'b00};
                state_d    = RESP;
                if (!in_range) begin
                    err_d = 1'b1;
                end else if (!we_q) begin
                    rdata_d = mem_data_out_i;
                end else if (be_q == 4'b1111) begin
                    mem_wr_en_o   = 1'b1;
                    mem_data_in_o = wdata_q;
                end else if (be_q != 4'b0000) begin
                    wdata_d = merged;
                    state_d = MERGE_WR;
                end
            end
            MERGE_WR: begin
                mem_addr_o    = {addr_q[31:2], 2'b00};
                mem_data_in_o = wdata_q;
                mem_wr_en_o   = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // ready is combinational on valid, so it is masked while reset is held.
    assign req0.ready      = rdy0 & rst_n;
    assign req1.ready      = rdy1 & rst_n;
    assign req0.resp_valid = (state_q == RESP) && !gnt_q;
    assign req1.resp_valid = (state_q == RESP) &&  gnt_q;
    assign req0.resp_rdata = req0.resp_valid ? rdata_q : 32'h0;
    assign req1.resp_rdata = req1.resp_valid ? rdata_q : 32'h0;
    assign req0.resp_err   = req0.resp_valid & err_q;
    assign req1.resp_err   = req1.resp_valid & err_q;

endmodule
